// File: rtl/stack_ram_ctrl_if.sv
// Bundle of the stack request/response signals and the single-port RAM port.
// The slave modport is the controller; the master modport is the user plus RAM.
interface stack_ram_ctrl_if #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 8
) ();
   logic                  clear;
   logic                  push;
   logic                  pop;
   logic [DATA_WIDTH-1:0] w_data;
   logic [DATA_WIDTH-1:0] r_data;
   logic                  r_valid;
   logic                  empty;
   logic                  full;
   logic [ADDR_WIDTH:0]   count;
   logic                  err;
   logic                  ram_we;
   logic [ADDR_WIDTH-1:0] ram_addr;
   logic [DATA_WIDTH-1:0] ram_din;
   logic [DATA_WIDTH-1:0] ram_dout;

   modport slave (
      input  clear, push, pop, w_data, ram_dout,
      output r_data, r_valid, empty, full, count, err, ram_we, ram_addr, ram_din
   );

   modport master (
      output clear, push, pop, w_data, ram_dout,
      input  r_data, r_valid, empty, full, count, err, ram_we, ram_addr, ram_din
   );
endinterface

// File: rtl/stack_ram_ctrl.sv
// LIFO stack controller over an external single-port synchronous-read RAM.
// Pop data comes straight from the RAM output one cycle after the request.
module stack_ram_ctrl #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   stack_ram_ctrl_if.slave  bus
);
   localparam logic [ADDR_WIDTH:0] L_DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
   localparam logic [ADDR_WIDTH:0] L_ZERO  = {(ADDR_WIDTH+1){1'b0}};
   localparam logic [ADDR_WIDTH:0] L_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      OP_IDLE  = 2'd0,
      OP_FLUSH = 2'd1,
      OP_POP   = 2'd2,
      OP_PUSH  = 2'd3
   } op_t;

   logic [ADDR_WIDTH:0]   r_ptr;
   logic                  r_valid_q;
   logic                  r_err;
   logic                  w_empty;
   logic                  w_full;
   op_t                   w_op;
   logic                  w_err_next;
   logic [ADDR_WIDTH-1:0] w_ptr_m1;

   assign w_empty  = (r_ptr == L_ZERO);
   assign w_full   = (r_ptr == L_DEPTH);
   assign w_ptr_m1 = r_ptr[ADDR_WIDTH-1:0] - ADDR_WIDTH'(1);

   // Request decode in priority order: clear, pop, push, idle.
   always_comb begin
      w_op = OP_IDLE;
      if (bus.clear) begin
         w_op = OP_FLUSH;
      end else if (bus.pop && !w_empty) begin
         w_op = OP_POP;
      end else if (bus.push && !w_full) begin
         w_op = OP_PUSH;
      end else begin
         w_op = OP_IDLE;
      end
   end

   // Rejected requests: overflow, underflow, and a push dropped in favour of a pop.
   always_comb begin
      w_err_next = 1'b0;
      if (bus.clear) begin
         w_err_next = 1'b0;
      end else begin
         w_err_next = (bus.push && w_full && !bus.pop)
                    | (bus.pop && w_empty && !bus.push)
                    | (bus.push && bus.pop && !w_empty);
      end
   end

   // RAM port is combinational from the decode so a push writes in its own cycle.
   always_comb begin
      bus.ram_we   = 1'b0;
      bus.ram_addr = w_ptr_m1;
      bus.ram_din  = bus.w_data;
      case (w_op)
         OP_PUSH: begin
            bus.ram_we   = !reset;
            bus.ram_addr = r_ptr[ADDR_WIDTH-1:0];
         end
         OP_POP: begin
            bus.ram_we   = 1'b0;
            bus.ram_addr = w_ptr_m1;
         end
         default: begin
            bus.ram_we   = 1'b0;
            bus.ram_addr = w_ptr_m1;
         end
      endcase
   end

   // Pointer and the two one-cycle strobes.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ptr     <= L_ZERO;
         r_valid_q <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         r_valid_q <= (w_op == OP_POP);
         r_err     <= w_err_next;
         case (w_op)
            OP_FLUSH: r_ptr <= L_ZERO;
            OP_POP:   r_ptr <= r_ptr - L_ONE;
            OP_PUSH:  r_ptr <= r_ptr + L_ONE;
            default:  r_ptr <= r_ptr;
         endcase
      end
   end

   assign bus.r_data  = bus.ram_dout;
   assign bus.r_valid = r_valid_q;
   assign bus.err     = r_err;
   assign bus.empty   = w_empty;
   assign bus.full    = w_full;
   assign bus.count   = r_ptr;
endmodule
